mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the shared 512x32 synchronous RAM.
- Port A: instruction-fetch side. Port B: load/store datapath side.
- Resolves per-cycle conflicts round-robin, drives the RAM address, write data and write enable, and returns read data with a valid strobe that matches the RAM's one-cycle registered-address read latency.
- Port B can lock the RAM for back-to-back read-modify-write sequences.

Parameters:
ADDR_W, 9, RAM word-address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock, rising edge
clear  in  1  synchronous active-high reset
req_a  in  1  port A request; held with addr/we/wdata until gnt_a
we_a  in  1  port A write (1) / read (0)
addr_a  in  ADDR_W  port A address
wdata_a  in  DATA_W  port A write data
gnt_a  out  1  port A granted this cycle (combinational)
rvalid_a  out  1  port A read data valid (registered)
rdata_a  out  DATA_W  port A read data
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as port A, for port B
lock_b  in  1  keep the RAM reserved for B after the current grant
ram_address  out  ADDR_W  to RAM address
ram_data_in  out  DATA_W  to RAM data_in
ram_write_enable  out  1  to RAM writeEnable
ram_data_out  in  DATA_W  from RAM data_out

Behaviour:
- Reset is synchronous to clk, active-high on clear. Values after the clear edge:
  - rvalid_a=0, rvalid_b=0, locked=0, last_gnt=B (so A wins the first tie).
- While clear=1: gnt_a=0, gnt_b=0, ram_write_enable=0, no access issued.
- Grant (combinational, at most one grant per cycle):
  - locked=1: gnt_b=req_b, gnt_a=0. A is held off even if B is idle.
  - Exactly one requester active: grant it.
  - Both active: grant the port not equal to last_gnt.
  - Neither active: no grant.
- RAM drive:
  - ram_address/ram_data_in come from the granted port.
  - ram_write_enable = grant & we of that port.
  - With no grant: ram_address=addr_a, ram_data_in=wdata_a, ram_write_enable=0.
- Registered updates on each rising edge:
  - last_gnt <= granted port, if any grant.
  - rvalid_x <= gnt_x & ~we_x.
- Read data and latency:
  - rdata_a = rdata_b = ram_data_out (unregistered passthrough). Valid only while the matching rvalid is high.
  - Read latency: 1 cycle from the grant edge.
  - Back-to-back grants pipeline at 1 access per cycle.
- Write-then-read to the same address on consecutive cycles returns the newly written data.
- Lock:
  - gnt_b & lock_b at an edge sets locked.
  - gnt_b & ~lock_b, or req_b=0 while locked, clears it.
  - While locked, req_a stays pending with gnt_a=0; A is served on the first cycle after unlock.
- Clear asserted mid-read: the pending rvalid is dropped, so no stale strobe appears after reset.
- Requesters must not change addr/we/wdata while req=1 and gnt=0. Behaviour is undefined if they do.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: adds outputs grant_cnt_a[15:0], grant_cnt_b[15:0], conflict_cnt[15:0].
  - Each counter is saturating and zeroed on clear.
  - grant_cnt_x increments on every grant to that port.
  - conflict_cnt increments on each cycle where req_a & req_b (locked cycles included).
- Undefined: no counter registers and no counter ports.

Decomposition:
- Package mem_arb_pkg: ADDR_W/DATA_W defaults, port-select enum {PORT_A, PORT_B}, STAT_W=16.
- One natural sub-module, rr_arb2: two-way round-robin picker with last-grant register and lock override. Top level holds the muxing, rvalid pipeline and optional stats.

Test Plan:
- Reset, then req_a read addr 0x010 (RAM holds 0xDEADBEEF) -> gnt_a same cycle; next cycle rvalid_a=1, rdata_a=0xDEADBEEF; rvalid_b=0.
- req_a and req_b held 4 cycles, both reads -> grants alternate A,B,A,B; each rvalid follows its grant by one cycle.
- B write 0x12345678 to 0x1FF, then A read 0x1FF next cycle -> ram_write_enable=1 only in the write cycle; rdata_a=0x12345678.
- lock_b held for 3 B grants with req_a asserted -> gnt_a=0 for those 3 cycles; gnt_a=1 on the cycle after lock_b drops.
- Read granted, clear asserted the following cycle -> rvalid drops to 0; ram_write_enable=0 during clear; after release, A wins the first tie.
- MEM_ARB_STATS_EN defined, 70000 conflicting cycles -> conflict_cnt saturates at 0xFFFF; clear returns all counters to 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter (mem_arbiter, rr_arb2).
package mem_arb_pkg;

  localparam int ADDR_W_DEFAULT = 9;
  localparam int DATA_W_DEFAULT = 32;
  localparam int STAT_W         = 16;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    if (value == {STAT_W{1'b1}}) begin
      return value;
    end else begin
      return value + STAT_W'(1);
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin picker with last-grant memory and a port-B lock that holds off port A.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic req_a,
  input  logic req_b,
  input  logic lock_b,
  output logic gnt_a,
  output logic gnt_b
);

  port_e last_r;
  port_e last_nxt;
  logic  locked_r;
  logic  locked_nxt;

  // state register
  always_ff @(posedge clk) begin
    if (clear) begin
      last_r   <= PORT_B;
      locked_r <= 1'b0;
    end else begin
      last_r   <= last_nxt;
      locked_r <= locked_nxt;
    end
  end

  // next state: remember the winner; a B grant re-decides the lock, B going idle releases it
  always_comb begin
    last_nxt   = last_r;
    locked_nxt = locked_r;
    if (gnt_a) begin
      last_nxt = PORT_A;
    end else if (gnt_b) begin
      last_nxt = PORT_B;
    end else begin
      last_nxt = last_r;
    end
    if (gnt_b) begin
      locked_nxt = lock_b;
    end else if (locked_r && !req_b) begin
      locked_nxt = 1'b0;
    end else begin
      locked_nxt = locked_r;
    end
  end

  // grant outputs
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (clear) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end else if (locked_r) begin
      gnt_a = 1'b0;
      gnt_b = req_b;
    end else if (req_a && req_b) begin
      gnt_a = (last_r == PORT_B);
      gnt_b = (last_r == PORT_A);
    end else begin
      gnt_a = req_a;
      gnt_b = req_b;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for a shared 512x32 synchronous RAM with one-cycle read latency.
// Define MEM_ARB_STATS_EN to add saturating grant and conflict counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              lock_b,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] grant_cnt_a,
  output logic [STAT_W-1:0] grant_cnt_b,
  output logic [STAT_W-1:0] conflict_cnt
`endif
);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .clear  (clear),
    .req_a  (req_a),
    .req_b  (req_b),
    .lock_b (lock_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b)
  );

  // RAM drive follows the granted port; idle cycles park on port A with writes disabled
  always_comb begin
    ram_address      = addr_a;
    ram_data_in      = wdata_a;
    ram_write_enable = 1'b0;
    if (gnt_b) begin
      ram_address      = addr_b;
      ram_data_in      = wdata_b;
      ram_write_enable = we_b;
    end else if (gnt_a) begin
      ram_address      = addr_a;
      ram_data_in      = wdata_a;
      ram_write_enable = we_a;
    end else begin
      ram_address      = addr_a;
      ram_data_in      = wdata_a;
      ram_write_enable = 1'b0;
    end
  end

  // read-valid strobes track the RAM's registered-address latency
  always_ff @(posedge clk) begin
    if (clear) begin
      rvalid_a <= 1'b0;
      rvalid_b <= 1'b0;
    end else begin
      rvalid_a <= gnt_a & ~we_a;
      rvalid_b <= gnt_b & ~we_b;
    end
  end

  assign rdata_a = ram_data_out;
  assign rdata_b = ram_data_out;

`ifdef MEM_ARB_STATS_EN
  // saturating usage counters
  always_ff @(posedge clk) begin
    if (clear) begin
      grant_cnt_a  <= '0;
      grant_cnt_b  <= '0;
      conflict_cnt <= '0;
    end else begin
      grant_cnt_a  <= gnt_a ? sat_inc(grant_cnt_a) : grant_cnt_a;
      grant_cnt_b  <= gnt_b ? sat_inc(grant_cnt_b) : grant_cnt_b;
      conflict_cnt <= (req_a && req_b) ? sat_inc(conflict_cnt) : conflict_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM and a per-port read-data scoreboard.
module tb_mem_arbiter;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic        clk = 1'b0;
  logic        clear;
  logic        req_a, we_a, req_b, we_b, lock_b;
  logic [8:0]  addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic        gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [31:0] rdata_a, rdata_b;
  logic [8:0]  ram_address;
  logic [31:0] ram_data_in, ram_data_out;
  logic        ram_write_enable;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] grant_cnt_a, grant_cnt_b, conflict_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] model[512];
  logic        pend_a = 1'b0;
  logic        pend_b = 1'b0;

  logic [31:0] ram[512];
  logic [8:0]  ram_q_addr;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_enable) ram[ram_address] <= ram_data_in;
    ram_q_addr <= ram_address;
  end
  assign ram_data_out = ram[ram_q_addr];

  mem_arbiter dut (
    .clk(clk), .clear(clear),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .lock_b(lock_b),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
`ifdef MEM_ARB_STATS_EN
    , .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b), .conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock of stimulus: drive, check mid-cycle, update scoreboard, advance
  task automatic cyc(input logic clr, input logic ra, input logic wa, input logic [8:0] aa,
                     input logic [31:0] da, input logic rb, input logic wb, input logic [8:0] ab,
                     input logic [31:0] db, input logic lk, input logic ega, input logic egb);
    logic exp_we;
    clear = clr; req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db; lock_b = lk;
    #3;
    chk("rvalid_a", {31'd0, rvalid_a}, {31'd0, pend_a});
    chk("rvalid_b", {31'd0, rvalid_b}, {31'd0, pend_b});
    if (pend_a) begin
      if (q_a.size() == 0) chk("sb_a_empty", 32'd0, 32'd1);
      else chk("rdata_a", rdata_a, q_a.pop_front());
    end
    if (pend_b) begin
      if (q_b.size() == 0) chk("sb_b_empty", 32'd0, 32'd1);
      else chk("rdata_b", rdata_b, q_b.pop_front());
    end
    chk("gnt_a", {31'd0, gnt_a}, {31'd0, ega});
    chk("gnt_b", {31'd0, gnt_b}, {31'd0, egb});
    exp_we = (ega & wa) | (egb & wb);
    chk("ram_we", {31'd0, ram_write_enable}, {31'd0, exp_we});
    if (ega || egb) chk("ram_addr", {23'd0, ram_address}, {23'd0, (ega ? aa : ab)});
    if (exp_we) chk("ram_din", ram_data_in, (ega ? da : db));
    if (ega && wa) model[aa] = da;
    if (egb && wb) model[ab] = db;
    if (ega && !wa) q_a.push_back(model[aa]);
    if (egb && !wb) q_b.push_back(model[ab]);
    pend_a = ega & ~wa;
    pend_b = egb & ~wb;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(N, N, N, 9'h000, 32'h0, N, N, 9'h000, 32'h0, N, N, N);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      model[i] = 32'h0;
      ram[i]   = 32'h0;
    end
    model[9'h010] = 32'hDEADBEEF; ram[9'h010] = 32'hDEADBEEF;
    model[9'h020] = 32'hCAFEF00D; ram[9'h020] = 32'hCAFEF00D;
    model[9'h005] = 32'h55AA55AA; ram[9'h005] = 32'h55AA55AA;

    clear = Y; req_a = N; we_a = N; addr_a = 9'h0; wdata_a = 32'h0;
    req_b = N; we_b = N; addr_b = 9'h0; wdata_b = 32'h0; lock_b = N;
    @(posedge clk); #1;

    // requests during clear are ignored and nothing is written
    cyc(Y, Y, Y, 9'h1F0, 32'h1, Y, N, 9'h020, 32'h0, N, N, N);
    // single A read, then its data
    cyc(N, Y, N, 9'h010, 32'h0, N, N, 9'h000, 32'h0, N, Y, N);
    idle();
    // B read alone makes A the next tie winner
    cyc(N, N, N, 9'h000, 32'h0, Y, N, 9'h020, 32'h0, N, N, Y);
    // sustained conflict alternates A,B,A,B
    cyc(N, Y, N, 9'h010, 32'h0, Y, N, 9'h020, 32'h0, N, Y, N);
    cyc(N, Y, N, 9'h010, 32'h0, Y, N, 9'h020, 32'h0, N, N, Y);
    cyc(N, Y, N, 9'h010, 32'h0, Y, N, 9'h020, 32'h0, N, Y, N);
    cyc(N, Y, N, 9'h010, 32'h0, Y, N, 9'h020, 32'h0, N, N, Y);
    idle();
    // B write at top address, A reads it back the next cycle
    cyc(N, N, N, 9'h000, 32'h0, Y, Y, 9'h1FF, 32'h12345678, N, N, Y);
    cyc(N, Y, N, 9'h1FF, 32'h0, N, N, 9'h000, 32'h0, N, Y, N);
    idle();
    // lock: B holds the RAM for three grants while A waits
    cyc(N, Y, N, 9'h005, 32'h0, Y, N, 9'h020, 32'h0, Y, N, Y);
    cyc(N, Y, N, 9'h005, 32'h0, Y, N, 9'h020, 32'h0, Y, N, Y);
    cyc(N, Y, N, 9'h005, 32'h0, Y, N, 9'h020, 32'h0, N, N, Y);
    cyc(N, Y, N, 9'h005, 32'h0, N, N, 9'h000, 32'h0, N, Y, N);
    idle();
    // lock with B going idle: A is held off one cycle, then served
    cyc(N, N, N, 9'h000, 32'h0, Y, N, 9'h020, 32'h0, Y, N, Y);
    cyc(N, Y, N, 9'h005, 32'h0, N, N, 9'h000, 32'h0, N, N, N);
    cyc(N, Y, N, 9'h005, 32'h0, N, N, 9'h000, 32'h0, N, Y, N);
    idle();
    // clear right after a read grant: strobe dropped afterwards, A wins first tie
    cyc(N, Y, N, 9'h010, 32'h0, N, N, 9'h000, 32'h0, N, Y, N);
    cyc(Y, Y, Y, 9'h0AA, 32'h00000BAD, Y, Y, 9'h0BB, 32'h00000BAD, Y, N, N);
    cyc(N, Y, N, 9'h010, 32'h0, Y, N, 9'h020, 32'h0, N, Y, N);
    cyc(N, N, N, 9'h000, 32'h0, Y, N, 9'h020, 32'h0, N, N, Y);
    idle();
    chk("sb_drain", q_a.size() + q_b.size(), 32'd0);

`ifdef MEM_ARB_STATS_EN
    clear = Y; req_a = N; req_b = N; lock_b = N;
    @(posedge clk); #1;
    clear = N; req_a = Y; we_a = N; addr_a = 9'h010; req_b = Y; we_b = N; addr_b = 9'h020;
    repeat (70000) @(posedge clk);
    #1;
    req_a = N; req_b = N;
    #2;
    chk("conflict_sat", {16'd0, conflict_cnt}, 32'h0000FFFF);
    chk("grant_cnt_a", {16'd0, grant_cnt_a}, 32'd35000);
    chk("grant_cnt_b", {16'd0, grant_cnt_b}, 32'd35000);
    clear = Y;
    @(posedge clk); #1;
    clear = N;
    #2;
    chk("cnt_clear", {16'd0, grant_cnt_a | grant_cnt_b | conflict_cnt}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
